mult_acc_pipe: RTL and testbench

- Parametrised, valid-qualified multiply-add/accumulate pipeline for the DSP datapath.
- Successor to the fixed multiply-add slice, with these additions:
  - per-sample op select (add, subtract, accumulate);
  - a wide internal accumulator;
  - rounding right-shift and saturation to the output width, with a saturation flag.
- Sits between sample sources and filter/correlator back-ends; maps onto one DSP slice plus fabric for round/saturate.

---
 rtl/mult_acc_pipe.sv | 184 ++++++++++++++++++
 tb/tb_mult_acc_pipe.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/mult_acc_pipe.sv
// mult_acc_pipe: valid-qualified signed multiply-add/accumulate pipeline.
// It has four ce-gated stages:
//   S1 registers the inputs.
//   S2 forms the full-width product.
//   S3 updates the wide accumulator.
//   S4 applies a rounding arithmetic right shift, then saturates to PW bits
//      and raises a per-sample saturation flag.
// The accumulator feeds back onto itself inside S3, so accumulate ops can
// run back-to-back without bubbles.
module mult_acc_pipe #(
    parameter int AW    = 27,
    parameter int BW    = 18,
    parameter int CW    = 48,
    parameter int PW    = 48,
    parameter int ACCW  = 64,
    parameter int SHIFT = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ce,
    input  logic            vin,
    input  logic [1:0]      op,
    input  logic [AW-1:0]   ain,
    input  logic [BW-1:0]   bin,
    input  logic [CW-1:0]   cin,
    output logic            vout,
    output logic [PW-1:0]   pout,
    output logic            sat
);

    localparam int MW    = AW + BW;
    localparam int MAXIN = (MW > CW) ? MW : CW;

    // The accumulator must hold any single product or addend plus one bit
    // of headroom. The output and shift must also fit inside it.
    generate
        if (ACCW < MAXIN + 1) begin : g_bad_accw
            $error("mult_acc_pipe: ACCW too small for max(AW+BW, CW)+1");
        end
        if (SHIFT < 0 || SHIFT >= ACCW) begin : g_bad_shift
            $error("mult_acc_pipe: SHIFT must satisfy 0 <= SHIFT < ACCW");
        end
        if (PW > ACCW) begin : g_bad_pw
            $error("mult_acc_pipe: PW must not exceed ACCW");
        end
    endgenerate

    // Rounding and saturation work one bit wider than the accumulator, so
    // the half-LSB rounding add can never overflow.
    localparam logic signed [ACCW:0] ONE_W = 1;
    localparam logic signed [ACCW:0] RND   = (ONE_W << SHIFT) >> 1;
    localparam logic signed [ACCW:0] P_MAX = {{(ACCW + 2 - PW){1'b0}}, {(PW - 1){1'b1}}};
    localparam logic signed [ACCW:0] P_MIN = {{(ACCW + 2 - PW){1'b1}}, {(PW - 1){1'b0}}};

    // S1 registers
    logic signed [AW-1:0]   a1_reg;
    logic signed [BW-1:0]   b1_reg;
    logic signed [CW-1:0]   c1_reg;
    logic [1:0]             op1_reg;
    logic                   v1_reg;

    // S2 registers
    logic signed [MW-1:0]   m2_reg;
    logic signed [CW-1:0]   c2_reg;
    logic [1:0]             op2_reg;
    logic                   v2_reg;

    // S3 registers
    logic signed [ACCW-1:0] acc_reg;
    logic signed [ACCW-1:0] acc_next;
    logic                   v3_reg;

    // S4 registers
    logic                   vout_reg;
    logic [PW-1:0]          pout_reg;
    logic [PW-1:0]          pout_next;
    logic                   sat_reg;
    logic                   sat_next;

    logic signed [ACCW-1:0] m_ext;
    logic signed [ACCW-1:0] c_ext;
    logic signed [ACCW:0]   sum_wide;
    logic signed [ACCW:0]   shifted;

    // S1: capture the incoming sample and its controls.
    always_ff @(posedge clk) begin
        if (rst) begin
            a1_reg  <= '0;
            b1_reg  <= '0;
            c1_reg  <= '0;
            op1_reg <= '0;
            v1_reg  <= 1'b0;
        end else if (ce) begin
            a1_reg  <= ain;
            b1_reg  <= bin;
            c1_reg  <= cin;
            op1_reg <= op;
            v1_reg  <= vin;
        end
    end

    // S2: form the full-precision signed product and carry the addend and op along.
    always_ff @(posedge clk) begin
        if (rst) begin
            m2_reg  <= '0;
            c2_reg  <= '0;
            op2_reg <= '0;
            v2_reg  <= 1'b0;
        end else if (ce) begin
            m2_reg  <= a1_reg * b1_reg;
            c2_reg  <= c1_reg;
            op2_reg <= op2_next_op(op1_reg);
            v2_reg  <= v1_reg;
        end
    end

    function automatic logic [1:0] op2_next_op(input logic [1:0] o);
        return o;
    endfunction

    // S3: sign-extend, then select the next accumulator value.
    // Bubbles leave the running sum untouched.
    always_comb begin
        m_ext    = {{(ACCW - MW){m2_reg[MW-1]}}, m2_reg};
        c_ext    = {{(ACCW - CW){c2_reg[CW-1]}}, c2_reg};
        acc_next = acc_reg;
        if (v2_reg) begin
            case (op2_reg)
                2'b00:   acc_next = c_ext + m_ext;
                2'b01:   acc_next = c_ext - m_ext;
                2'b10:   acc_next = acc_reg + m_ext;
                default: acc_next = acc_reg - m_ext;
            endcase
        end
    end

    // S3: accumulator and valid register.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg <= '0;
            v3_reg  <= 1'b0;
        end else if (ce) begin
            acc_reg <= acc_next;
            v3_reg  <= v2_reg;
        end
    end

    // S4: round half toward +inf, arithmetic shift, then clip to the output range.
    always_comb begin
        sum_wide = {acc_reg[ACCW-1], acc_reg} + RND;
        shifted  = sum_wide >>> SHIFT;
        sat_next = 1'b0;
        if (shifted > P_MAX) begin
            pout_next = P_MAX[PW-1:0];
            sat_next  = 1'b1;
        end else if (shifted < P_MIN) begin
            pout_next = P_MIN[PW-1:0];
            sat_next  = 1'b1;
        end else begin
            pout_next = shifted[PW-1:0];
        end
    end

    // S4: output registers.
    // pout and sat only move on a valid sample and otherwise keep the last result.
    always_ff @(posedge clk) begin
        if (rst) begin
            vout_reg <= 1'b0;
            pout_reg <= '0;
            sat_reg  <= 1'b0;
        end else if (ce) begin
            vout_reg <= v3_reg;
            if (v3_reg) begin
                pout_reg <= pout_next;
                sat_reg  <= sat_next;
            end
        end
    end

    assign vout = vout_reg;
    assign pout = pout_reg;
    assign sat  = sat_reg;

endmodule

// File: tb/tb_mult_acc_pipe.sv
// Directed self-checking bench for mult_acc_pipe.
// It runs two instances on the same stimulus: SHIFT=0 and SHIFT=4.
module tb_mult_acc_pipe;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               ce  = 1'b1;
    logic               vin = 1'b0;
    logic [1:0]         op  = 2'b00;
    logic [26:0]        ain = '0;
    logic [17:0]        bin = '0;
    logic [47:0]        cin = '0;

    logic               vout;
    logic signed [47:0] pout;
    logic               sat;
    logic               vout4;
    logic signed [47:0] pout4;
    logic               sat4;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    longint q_pout[$];
    int     q_cyc[$];
    longint q_sat[$];
    longint q4_pout[$];
    longint q4_sat[$];

    mult_acc_pipe #(.AW(27), .BW(18), .CW(48), .PW(48), .ACCW(64), .SHIFT(0)) dut (
        .clk(clk), .rst(rst), .ce(ce), .vin(vin), .op(op),
        .ain(ain), .bin(bin), .cin(cin),
        .vout(vout), .pout(pout), .sat(sat)
    );

    mult_acc_pipe #(.AW(27), .BW(18), .CW(48), .PW(48), .ACCW(64), .SHIFT(4)) dut4 (
        .clk(clk), .rst(rst), .ce(ce), .vin(vin), .op(op),
        .ain(ain), .bin(bin), .cin(cin),
        .vout(vout4), .pout(pout4), .sat(sat4)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint got, input longint exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // One clock; outputs are sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        if (ce && vout) begin
            q_pout.push_back(pout);
            q_sat.push_back(longint'(sat));
            q_cyc.push_back(cyc);
        end
        if (ce && vout4) begin
            q4_pout.push_back(pout4);
            q4_sat.push_back(longint'(sat4));
        end
    endtask

    task automatic drive(input logic c_e, input logic v, input logic [1:0] o,
                         input longint a, input longint b, input longint c);
        ce  = c_e;
        vin = v;
        op  = o;
        ain = a[26:0];
        bin = b[17:0];
        cin = c[47:0];
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 2'b00, 0, 0, 0);
    endtask

    task automatic clear_q();
        q_pout.delete();
        q_sat.delete();
        q_cyc.delete();
        q4_pout.delete();
        q4_sat.delete();
    endtask

    int s;
    longint exp_p[3];
    int     exp_c[3];

    initial begin
        // Reset state
        rst = 1'b1;
        tick();
        tick();
        check("rst_vout", longint'(vout), 0);
        check("rst_pout", pout, 0);
        check("rst_sat", longint'(sat), 0);
        rst = 1'b0;
        clear_q();

        // Single sample: 100 + 3*-5 = 85, with a latency of 4 cycles
        s = cyc;
        drive(1'b1, 1'b1, 2'b00, 3, -5, 100);
        idle(8);
        check("single_count", q_pout.size(), 1);
        if (q_pout.size() == 1) begin
            check("single_pout", q_pout[0], 85);
            check("single_sat", q_sat[0], 0);
            check("single_cyc", q_cyc[0], s + 4);
        end
        clear_q();

        // Back-to-back accumulate: 10+6=16, 16+20=36, 36-1=35
        s = cyc;
        drive(1'b1, 1'b1, 2'b00, 2, 3, 10);
        drive(1'b1, 1'b1, 2'b10, 4, 5, 0);
        drive(1'b1, 1'b1, 2'b11, 1, 1, 0);
        idle(8);
        exp_p = '{16, 36, 35};
        exp_c = '{s + 4, s + 5, s + 6};
        check("b2b_count", q_pout.size(), 3);
        if (q_pout.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("b2b_pout%0d", i), q_pout[i], exp_p[i]);
                check($sformatf("b2b_cyc%0d", i), q_cyc[i], exp_c[i]);
            end
        end
        clear_q();

        // Same stream, with bubbles and ce gaps.
        // A ce=0 cycle carries a garbage op=00 sample that must be ignored.
        s = cyc;
        drive(1'b1, 1'b1, 2'b00, 2, 3, 10);          // t=s
        drive(1'b1, 1'b0, 2'b00, 0, 0, 0);           // bubble
        drive(1'b0, 1'b1, 2'b00, 100, 100, 999);     // ce=0, ignored
        drive(1'b1, 1'b1, 2'b10, 4, 5, 0);           // t=s+3
        drive(1'b0, 1'b0, 2'b00, 0, 0, 0);
        drive(1'b0, 1'b0, 2'b00, 0, 0, 0);
        drive(1'b1, 1'b0, 2'b00, 0, 0, 0);           // bubble
        drive(1'b1, 1'b1, 2'b11, 1, 1, 0);           // t=s+7
        idle(8);
        exp_p = '{16, 36, 35};
        exp_c = '{s + 7, s + 9, s + 11};
        check("gap_count", q_pout.size(), 3);
        if (q_pout.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("gap_pout%0d", i), q_pout[i], exp_p[i]);
                check($sformatf("gap_cyc%0d", i), q_cyc[i], exp_c[i]);
            end
        end
        clear_q();

        // Positive saturation: (2^47-1) + 1 clips to 2^47-1.
        // ce=0 holds the outputs, and pout/sat hold after vout drops.
        drive(1'b1, 1'b1, 2'b00, 1, 1, 64'h0000_7FFF_FFFF_FFFF);
        idle(3);
        check("sat_vout", longint'(vout), 1);
        check("sat_pout", pout, 64'h0000_7FFF_FFFF_FFFF);
        check("sat_flag", longint'(sat), 1);
        drive(1'b0, 1'b0, 2'b00, 0, 0, 0);
        check("ce0_vout_hold", longint'(vout), 1);
        check("ce0_pout_hold", pout, 64'h0000_7FFF_FFFF_FFFF);
        idle(1);
        check("idle_vout", longint'(vout), 0);
        check("idle_pout_hold", pout, 64'h0000_7FFF_FFFF_FFFF);
        check("idle_sat_hold", longint'(sat), 1);
        idle(4);
        clear_q();

        // SHIFT=4 rounding: 24 -> 2, -24 -> -1, -25 -> -2
        drive(1'b1, 1'b1, 2'b00, 0, 0, 24);
        drive(1'b1, 1'b1, 2'b00, 0, 0, -24);
        drive(1'b1, 1'b1, 2'b00, 0, 0, -25);
        idle(8);
        exp_p = '{2, -1, -2};
        check("rnd_count", q4_pout.size(), 3);
        if (q4_pout.size() == 3) begin
            for (int i = 0; i < 3; i++) begin
                check($sformatf("rnd_pout%0d", i), q4_pout[i], exp_p[i]);
                check($sformatf("rnd_sat%0d", i), q4_sat[i], 0);
            end
        end
        clear_q();

        // Reset with two samples in flight: neither appears.
        // acc restarts at 0, so the next op=10 sample gives 7*1 = 7.
        drive(1'b1, 1'b1, 2'b00, 1000, 1000, 5);
        drive(1'b1, 1'b1, 2'b10, 1000, 1000, 0);
        rst = 1'b1;
        drive(1'b1, 1'b0, 2'b00, 0, 0, 0);
        rst = 1'b0;
        check("midrst_pout", pout, 0);
        drive(1'b1, 1'b1, 2'b10, 7, 1, 0);
        idle(8);
        check("midrst_count", q_pout.size(), 1);
        if (q_pout.size() == 1) begin
            check("midrst_pout7", q_pout[0], 7);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
